// File: rtl/pe_ctrl_pkg.sv
// Shared widths, dataflow encoding and sequencer state encoding
// for the PE tile control path.
package pe_ctrl_pkg;

    localparam int A_W     = 8;
    localparam int BD_W    = 20;
    localparam int SHIFT_W = 5;
    localparam int ID_W    = 3;

    typedef enum logic {
        OS = 1'b0,
        WS = 1'b1
    } dataflow_e;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DRAIN = 2'd1,
        RUN        = 2'd2
    } state_e;

endpackage

// File: rtl/pe_inflight_tracker.sv
// Counts issued-but-unretired commands, checks that retires come
// back in issue order, and emits a one-cycle done pulse per retire.
module pe_inflight_tracker
    import pe_ctrl_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic             res_valid,
    input  logic             res_last,
    input  logic [ID_W-1:0]  res_id,
    output logic [CNT_W-1:0] inflight,
    output logic             done_valid,
    output logic [ID_W-1:0]  done_id,
    output logic             err
);

    logic            retire;
    logic [ID_W-1:0] id_rd;
    logic            empty;

    assign retire = res_valid && res_last;
    assign empty  = (inflight == '0);

    // Retire bookkeeping: done pulse, expected-id pointer, sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_valid <= 1'b0;
            done_id    <= '0;
            id_rd      <= '0;
            err        <= 1'b0;
        end else begin
            done_valid <= retire;
            if (retire) begin
                done_id <= res_id;
                id_rd   <= id_rd + ID_W'(1);
                if (res_id != id_rd || empty) begin
                    err <= 1'b1;
                end
            end
        end
    end

    // In-flight count; a retire with nothing outstanding leaves it at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            unique case ({accept, retire})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   if (!empty) inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: rtl/pe_tile_sequencer.sv
// Issues compute commands to one PE: streams operand beats with their
// control tuple and throttles on in-flight count and dataflow changes.
module pe_tile_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int LEN_W        = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dataflow,
    input  logic               cmd_preload,
    input  logic [SHIFT_W-1:0] cmd_shift,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [A_W-1:0]     op_a,
    input  logic [BD_W-1:0]    op_b,
    input  logic [BD_W-1:0]    op_d,
    output logic               pe_valid,
    output logic [A_W-1:0]     pe_a,
    output logic [BD_W-1:0]    pe_b,
    output logic [BD_W-1:0]    pe_d,
    output logic               pe_dataflow,
    output logic               pe_propagate,
    output logic [SHIFT_W-1:0] pe_shift,
    output logic [ID_W-1:0]    pe_id,
    output logic               pe_last,
    input  logic               res_valid,
    input  logic               res_last,
    input  logic [ID_W-1:0]    res_id,
    output logic               done_valid,
    output logic [ID_W-1:0]    done_id,
    output logic               err
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT_DRAIN;
    localparam logic [1:0] ST_RUN  = RUN;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [CNT_W-1:0]   inflight;
    logic               cur_df;
    logic               prop;
    logic [SHIFT_W-1:0] shift_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beat_q;
    logic [ID_W-1:0]    id_wr;
    logic [ID_W-1:0]    cur_id;
    logic               idle;
    logic               busy;
    logic               df_ok;
    logic               df_change;
    logic               accept;
    logic               beat;
    logic               last_beat;

    assign idle      = (state_q == ST_IDLE);
    assign busy      = (inflight != '0);
    assign df_ok     = !busy || (cmd_dataflow == cur_df);
    assign df_change = busy && (cmd_dataflow != cur_df);
    assign cmd_ready = rst && idle && (inflight < MAX_CNT) && df_ok;
    assign op_ready  = (state_q == ST_RUN);
    assign accept    = cmd_valid && cmd_ready;
    assign beat      = op_valid && op_ready;
    assign last_beat = (beat_q == len_q);

    pe_inflight_tracker #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_W        (CNT_W)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .accept     (accept),
        .res_valid  (res_valid),
        .res_last   (res_last),
        .res_id     (res_id),
        .inflight   (inflight),
        .done_valid (done_valid),
        .done_id    (done_id),
        .err        (err)
    );

    // Next-state: accept starts RUN, a pending dataflow switch waits for drain.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                end else if (cmd_valid && df_change) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: if (!busy) state_d = ST_IDLE;
            ST_RUN:  if (beat && last_beat) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Command context: latched on accept, beat counter advanced per beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cur_df  <= 1'b0;
            prop    <= 1'b0;
            shift_q <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            id_wr   <= '0;
            cur_id  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cur_df  <= cmd_dataflow;
                shift_q <= cmd_shift;
                len_q   <= cmd_len;
                beat_q  <= '0;
                cur_id  <= id_wr;
                id_wr   <= id_wr + ID_W'(1);
                if (cmd_preload) prop <= ~prop;
            end else if (beat && !last_beat) begin
                beat_q <= beat_q + LEN_W'(1);
            end
        end
    end

    // PE-facing registers: operands and tuple update only on a beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pe_valid     <= 1'b0;
            pe_a         <= '0;
            pe_b         <= '0;
            pe_d         <= '0;
            pe_dataflow  <= 1'b0;
            pe_propagate <= 1'b0;
            pe_shift     <= '0;
            pe_id        <= '0;
            pe_last      <= 1'b0;
        end else begin
            pe_valid <= beat;
            if (beat) begin
                pe_a         <= op_a;
                pe_b         <= op_b;
                pe_d         <= op_d;
                pe_dataflow  <= cur_df;
                pe_propagate <= prop;
                pe_shift     <= shift_q;
                pe_id        <= cur_id;
                pe_last      <= last_beat;
            end
        end
    end

endmodule

// File: doc/pe_tile_sequencer.md
# pe_tile_sequencer

Sequences one systolic PE (or PE row) of the mesh. It accepts compute commands and streams operand beats into the PE with the matching control tuple: dataflow, propagate, shift, id and last. It also tracks in-flight commands, using the PE's returned last/id, so that it can throttle issue and block dataflow switches until the PE pipeline drains. It sits between the mesh command queue and the PE input ports.

## Interface
- `MAX_INFLIGHT`, 4, maximum commands issued but not yet retired; range 1..8.
- `LEN_W`, 4, width of `cmd_len`; a command carries 1..2^LEN_W beats.

- `clk` in 1: sole clock.
- `rst` in 1: reset, asynchronous and active-low.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_dataflow` in 1: 0 = OS, 1 = WS.
- `cmd_preload` in 1: 1 = toggle propagate for this command.
- `cmd_shift` in 5: output shift.
- `cmd_len` in LEN_W: beat count minus 1.
- `op_valid` in 1 / `op_ready` out 1: operand beat handshake.
- `op_a` in 8, `op_b` in 20, `op_d` in 20: operands.
- `pe_valid` out 1: beat valid to PE.
- `pe_a` out 8, `pe_b` out 20, `pe_d` out 20: operands to PE.
- `pe_dataflow` out 1, `pe_propagate` out 1, `pe_shift` out 5, `pe_id` out 3, `pe_last` out 1: control tuple to PE.
- `res_valid` in 1, `res_last` in 1, `res_id` in 3: PE output-side valid, last and id.
- `done_valid` out 1, `done_id` out 3: one-cycle pulse per retired command.
- `err` out 1: sticky retire-order error.

## Operation
- States: IDLE, WAIT_DRAIN, RUN.
- IDLE:
  - `cmd_ready` = (inflight < MAX_INFLIGHT) && (inflight == 0 || `cmd_dataflow` == `cur_df`).
  - If `cmd_valid` with a dataflow change while inflight > 0, go to WAIT_DRAIN; `cmd_ready` stays 0.
- WAIT_DRAIN: return to IDLE when inflight == 0.
- Command accept (IDLE, `cmd_valid` && `cmd_ready`):
  - Latch dataflow, shift and len.
  - `cur_df` <= `cmd_dataflow`.
  - If `cmd_preload`, `prop` <= ~`prop`.
  - Assign id = `id_wr`; `id_wr`++ (3-bit wrap, 7 -> 0).
  - inflight++; beat counter <= 0; go to RUN.
- RUN:
  - `op_ready` = 1 (the PE has no backpressure).
  - Each `op_valid` beat registers operands plus the control tuple onto the `pe_*` outputs with `pe_valid` = 1.
  - `pe_last` = 1 when beat counter == latched len.
  - After the last beat, go to IDLE.
  - Cycles without `op_valid` drive `pe_valid` = 0. Operand and tuple outputs hold their last values.
- Outside RUN: `op_ready` = 0 and `pe_valid` = 0.
- Retire on `res_valid` && `res_last`:
  - inflight--; `done_valid` <= 1 and `done_id` <= `res_id` (registered pulse).
  - If `res_id` != `id_rd`, set `err` (sticky until reset).
  - `id_rd`++ (3-bit wrap, 7 -> 0).
- Simultaneous accept and retire: inflight unchanged.
- Retire with inflight == 0: set `err`; the counter does not underflow.
- Beat counter width is LEN_W; it never wraps within a command.

## Timing
- Reset (`rst` = 0, asynchronous):
  - State IDLE; inflight 0; `id_wr` = `id_rd` = 0; `prop` 0; `cur_df` 0.
  - All `pe_*` outputs 0; `done_valid` 0, `done_id` 0, `err` 0; `op_ready` 0.
  - `cmd_ready` is 0 while `rst` = 0.
- Reset mid-command drops the command: no further beats and no `done` pulse.
- Latency: an operand beat accepted at edge N appears on `pe_*` after edge N (1 cycle, registered).
- First beat of a command can be accepted the cycle after command accept.
- Back-to-back commands: one-cycle IDLE bubble between the last beat and the next accept.
- `done_valid` asserts one cycle after the retire input.
- `cmd_ready` and `op_ready` are combinational from state and counters only. They never depend on `cmd_valid` or `op_valid`, except for the dataflow compare.

## Structure
- Package `pe_ctrl_pkg`: A_W=8, BD_W=20, SHIFT_W=5, ID_W=3; dataflow enum (OS=0, WS=1); state enum {IDLE, WAIT_DRAIN, RUN}.
- Sub-module `pe_inflight_tracker`: inflight counter, `id_rd`, retire-order check, `err`, and the `done` pulse.
- Top-level contents: FSM, beat counter, `id_wr`, propagate toggle, output registers.

## Test plan
- Single command (len=3 → 4 beats, WS, shift=5, preload=1), `op_valid` held high:
  - 4 consecutive `pe_valid` cycles; `pe_propagate` = 1, `pe_id` = 0, `pe_last` only on beat 4.
  - After `res_last` id 0: `done_id` = 0 next cycle.
- Operand gaps: `op_valid` toggling 1,0,1,0 during len=1 → `pe_valid` follows one cycle later; `pe_last` on the 2nd valid beat only.
- Throttle: MAX_INFLIGHT=4, 4 commands with no retire:
  - `cmd_ready` = 0 for the 5th command.
  - Retire id 0 → 5th accepted with id 4.
- Dataflow switch: OS command in flight, WS command pending:
  - WAIT_DRAIN with no WS beats issued until retire.
  - Then WS issues with `pe_dataflow` = 1.
- ID wrap and order error:
  - 9 commands retired in order → ids 0..7, 0; `err` = 0.
  - Then retire `res_id` = 3 when 1 is expected → `err` = 1 and sticky.
- Async reset asserted mid-RUN (beat 2 of 8) → all outputs 0 immediately; after release, a new command gets id 0 and `prop` toggles 0 → 1.
